// File: rtl/sevenseg_scanner.sv
// Multiplexed scan controller for common-anode seven-segment digits.
// Double-buffered display data commits only at frame boundaries; dead time between digits.
//
// state | meaning
// BLANK | all digits off for DEAD cycles before the next digit is lit
// SHOW  | digit idx lit (unless masked) for PRESCALE cycles
module sevenseg_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 2500,
    parameter int DEAD       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    output logic [3:0]                value_out,
    output logic [NUM_DIGITS-1:0]     digit_en,
    output logic                      frame_done,
    output logic                      pending
);

    localparam int MAXC = (PRESCALE > DEAD) ? PRESCALE : DEAD;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int W    = 4 * NUM_DIGITS;
    localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    typedef enum logic {BLANK, SHOW} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [W-1:0]    active, active_nxt;
    logic [W-1:0]    shadow;
    logic            boundary;

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cnt_nxt    = cnt + 1'b1;
        active_nxt = active;
        boundary   = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == CW'(DEAD - 1)) begin
                    state_nxt = SHOW;
                    cnt_nxt   = '0;
                end
            end
            SHOW: begin
                if (cnt == CW'(PRESCALE - 1)) begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    if (idx == LAST_IDX) begin
                        idx_nxt  = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: state_nxt = BLANK;
        endcase
        // Commit reads the shadow as it was before this edge, so a same-cycle load survives.
        if (boundary && pending)
            active_nxt = shadow;
    end

    // Outputs are computed from next-state values so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BLANK;
            idx        <= '0;
            cnt        <= '0;
            active     <= '1;
            shadow     <= '1;
            pending    <= 1'b0;
            value_out  <= 4'hF;
            digit_en   <= '1;
            frame_done <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            cnt    <= cnt_nxt;
            active <= active_nxt;
            if (load) begin
                shadow  <= data_in;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
            value_out <= active_nxt[4*idx_nxt +: 4];
            if (state_nxt == SHOW && !blank_mask[idx_nxt])
                digit_en <= ~(ONE_HOT0 << idx_nxt);
            else
                digit_en <= '1;
            frame_done <= (state_nxt == SHOW) && (idx_nxt == LAST_IDX) &&
                          (cnt_nxt == CW'(PRESCALE - 1));
        end
    end

endmodule

// File: doc/sevenseg_scanner.md
# sevenseg_scanner

Time-multiplexed scan controller that shares one `SevenSeg` decoder between `NUM_DIGITS` common-anode digits. Each cycle it presents one 4-bit digit code on `value_out`, which feeds the decoder's `value` input. It also drives the matching active-low digit enable. New display contents are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new data. A dead-time interval between digits prevents ghosting.

## Interface
- `NUM_DIGITS`, default 4: number of multiplexed digits, 2..8.
- `PRESCALE`, default 2500: clock cycles each digit is lit (SHOW dwell), ≥1.
- `DEAD`, default 16: clock cycles all digits are off before each SHOW, ≥1.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load`  in  1  single-cycle strobe that captures `data_in` into the shadow buffer.
- `data_in`  in  4*NUM_DIGITS  digit codes; digit k is `[4k+3:4k]`, digit 0 is rightmost.
- `blank_mask`  in  NUM_DIGITS  1 = keep digit k dark; sampled live.
- `value_out`  out  4  code for the currently selected digit, to the `SevenSeg` decoder.
- `digit_en`  out  NUM_DIGITS  active-low digit enables; at most one bit is 0.
- `frame_done`  out  1  one-cycle pulse on the last SHOW cycle of the final digit.
- `pending`  out  1  shadow buffer holds data not yet committed.

## Operation
- Storage:
  - active buffer, NUM_DIGITS×4 bits.
  - shadow buffer, NUM_DIGITS×4 bits.
  - `pending` flag.
  - digit index `idx`, width clog2(NUM_DIGITS).
  - dwell counter, wide enough for max(PRESCALE, DEAD)−1.
  - state: BLANK or SHOW.
- On reset:
  - state = BLANK, idx = 0, counter = 0.
  - Every active and shadow entry = 4'hF, so the decoder shows a dash.
  - `pending` = 0.
- BLANK state:
  - `digit_en` = all ones.
  - `value_out` = active[idx].
  - After DEAD cycles, go to SHOW and clear the counter.
- SHOW state:
  - `digit_en[idx]` = 0, unless `blank_mask[idx]` = 1, in which case all ones.
  - `value_out` = active[idx].
  - After PRESCALE cycles, go to BLANK, clear the counter, and set idx = idx+1.
  - When idx = NUM_DIGITS−1, idx wraps to 0.
- Frame boundary (the transition SHOW→BLANK with idx = NUM_DIGITS−1):
  - If `pending` = 1: active ← shadow and `pending` ← 0.
  - Otherwise active is unchanged.
- `load` handling:
  - shadow ← `data_in` and `pending` ← 1.
  - A second `load` before commit overwrites the shadow. The last write wins.
- Simultaneous `load` and frame boundary:
  - The commit uses the shadow contents from before the edge.
  - The new `data_in` goes into the shadow.
  - `pending` stays 1, and the new data commits at the next frame boundary.
- Codes 10..15 pass through unchanged; the decoder renders them as a dash.
- Reset mid-frame: all state returns immediately to its reset values. Any uncommitted shadow data is lost.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs, except that `blank_mask` is registered one cycle before it affects `digit_en`.
- After `reset` deasserts:
  - Cycles 0..DEAD−1: BLANK, idx 0.
  - Cycles DEAD..DEAD+PRESCALE−1: SHOW, idx 0.
- Per-digit period = DEAD+PRESCALE cycles. Frame period = NUM_DIGITS×(DEAD+PRESCALE) cycles.
- `frame_done` is high for exactly one cycle: the final SHOW cycle of digit NUM_DIGITS−1.
- Commit latency:
  - New values appear on `value_out` starting at the first BLANK cycle of digit 0 of the next frame.
  - Worst case from `load` to display is one frame plus DEAD cycles.
- `pending` rises in the cycle after `load`. It falls in the cycle after the frame boundary, unless a `load` occurs in that same cycle.
- Reset values:
  - `digit_en` = all ones.
  - `value_out` = 4'hF.
  - `frame_done` = 0.
  - `pending` = 0.

## Test plan
All scenarios use PRESCALE=4, DEAD=1, NUM_DIGITS=4. Frame period = 20 cycles.

- **Reset state:** assert `reset` mid-SHOW.
  - Immediately: `digit_en`=4'b1111, `value_out`=4'hF, `pending`=0.
  - After release: the first enable is `digit_en`=4'b1110, beginning at cycle 1.
- **Scan sequence:** no `load`.
  - `digit_en` cycles 1110 → 1101 → 1011 → 0111, each low for 4 cycles.
  - Each low period is separated by 1 all-ones cycle.
  - `frame_done` pulses every 20 cycles.
- **Load/commit:** `load` with `data_in`=16'h4321 in cycle 3.
  - `pending`=1 from cycle 4.
  - `value_out`=4'hF until cycle 20.
  - Digit 0 shows 1, digit 1 shows 2, digit 2 shows 3, digit 3 shows 4.
  - `pending` returns to 0 at cycle 20.
- **Overwrite and collision:**
  - `load` 16'h1111, then `load` 16'h9999 before commit: only 9s are displayed.
  - `load` 16'h5555 on a `frame_done` cycle: the old shadow commits, `pending` stays 1, and 5s appear one frame later.
- **Blanking:** `blank_mask`=4'b0100.
  - Digit 2 never drives low; `digit_en` stays 1111 during its SHOW window.
  - Timing of the other digits is unchanged.
